// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory path: arbiter states, port ids and wait-counter sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DS
  } port_t;

  localparam int RD_LAT_MAX = 7;
  localparam int WAIT_CW    = 3;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick between instruction fetch and data ports.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic  req_if,
  input  logic  req_ds,
  input  port_t last_gnt,
  output port_t winner,
  output logic  valid
);

  always_comb begin
    valid  = req_if | req_ds;
    winner = PORT_IF;
    // On a tie the port that was not served last goes first.
    if (req_if && req_ds) begin
      winner = (last_gnt == PORT_DS) ? PORT_IF : PORT_DS;
    end else if (req_ds) begin
      winner = PORT_DS;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for the IF and DS masters: one access in flight,
// one-cycle strobes, read data returned after the RAM's fixed latency.
//
// state      | meaning
// ARB_IDLE   | no access in flight, arbitrate and latch the winner
// ARB_ACCESS | RAM strobe and gnt asserted for the owner
// ARB_WAIT   | counting down the RAM read latency
// ARB_RESP   | rvalid asserted for the owner with rdata held
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_if,
  input  logic             req_ds,
  input  logic             we_if,
  input  logic             we_ds,
  input  logic [AW-1:0]    addr_if,
  input  logic [AW-1:0]    addr_ds,
  input  logic [WIDTH-1:0] wdata_if,
  input  logic [WIDTH-1:0] wdata_ds,
  output logic             gnt_if,
  output logic             gnt_ds,
  output logic             rvalid_if,
  output logic             rvalid_ds,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_rd,
  output logic             ram_wr,
  input  logic [WIDTH-1:0] ram_rdata
);

  arb_state_t         state;
  port_t              owner;
  port_t              lastGnt;
  port_t              winner;
  logic               winValid;
  logic               opWe;
  logic [WAIT_CW-1:0] waitCnt;

  logic               selWe;
  logic [AW-1:0]      selAddr;
  logic [WIDTH-1:0]   selWdata;

  rr_arb2 uArb (
    .req_if   (req_if),
    .req_ds   (req_ds),
    .last_gnt (lastGnt),
    .winner   (winner),
    .valid    (winValid)
  );

  always_comb begin
    selWe    = we_if;
    selAddr  = addr_if;
    selWdata = wdata_if;
    if (winner == PORT_DS) begin
      selWe    = we_ds;
      selAddr  = addr_ds;
      selWdata = wdata_ds;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= PORT_IF;
      lastGnt   <= PORT_DS;
      opWe      <= 1'b0;
      waitCnt   <= '0;
      gnt_if    <= 1'b0;
      gnt_ds    <= 1'b0;
      rvalid_if <= 1'b0;
      rvalid_ds <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (winValid) begin
            owner     <= winner;
            opWe      <= selWe;
            ram_addr  <= selAddr;
            ram_wdata <= selWdata;
            ram_rd    <= ~selWe;
            ram_wr    <= selWe;
            gnt_if    <= (winner == PORT_IF);
            gnt_ds    <= (winner == PORT_DS);
            busy      <= 1'b1;
            state     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          ram_rd  <= 1'b0;
          ram_wr  <= 1'b0;
          gnt_if  <= 1'b0;
          gnt_ds  <= 1'b0;
          lastGnt <= owner;
          if (opWe) begin
            busy  <= 1'b0;
            state <= ARB_IDLE;
          end else begin
            waitCnt <= WAIT_CW'(RD_LAT - 1);
            state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // Count 0 is the cycle the RAM presents the word.
          if (waitCnt == '0) begin
            rdata     <= ram_rdata;
            rvalid_if <= (owner == PORT_IF);
            rvalid_ds <= (owner == PORT_DS);
            state     <= ARB_RESP;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        ARB_RESP: begin
          rvalid_if <= 1'b0;
          rvalid_ds <= 1'b0;
          busy      <= 1'b0;
          state     <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT 1 and 3) on shared stimulus, each
// tracked by a transaction-schedule model and a latency-accurate RAM stub.
module tb_ram_arbiter;
  import cpu_pkg::*;

  localparam int W  = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          reqIf = 1'b0, weIf = 1'b0, reqDs = 1'b0, weDs = 1'b0;
  logic [AW-1:0] addrIf = '0, addrDs = '0;
  logic [W-1:0]  wdataIf = '0, wdataDs = '0;

  logic          gntIf [2];
  logic          gntDs [2];
  logic          rvIf [2];
  logic          rvDs [2];
  logic          busyO [2];
  logic          ramRd [2];
  logic          ramWr [2];
  logic [W-1:0]  rdataO [2];
  logic [W-1:0]  ramWdata [2];
  logic [W-1:0]  ramRdata [2];
  logic [AW-1:0] ramAddr [2];

  for (genvar g = 0; g < 2; g++) begin : gDut
    ram_arbiter #(.WIDTH(W), .AW(AW), .RD_LAT(g == 0 ? 1 : 3)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_if    (reqIf),
      .req_ds    (reqDs),
      .we_if     (weIf),
      .we_ds     (weDs),
      .addr_if   (addrIf),
      .addr_ds   (addrDs),
      .wdata_if  (wdataIf),
      .wdata_ds  (wdataDs),
      .gnt_if    (gntIf[g]),
      .gnt_ds    (gntDs[g]),
      .rvalid_if (rvIf[g]),
      .rvalid_ds (rvDs[g]),
      .rdata     (rdataO[g]),
      .busy      (busyO[g]),
      .ram_addr  (ramAddr[g]),
      .ram_wdata (ramWdata[g]),
      .ram_rd    (ramRd[g]),
      .ram_wr    (ramWr[g]),
      .ram_rdata (ramRdata[g])
    );
  end

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;

  // Reference model: one transaction at a time, described by the cycles its events land in.
  int            freeAt [2];
  int            gntCyc [2];
  int            rvCyc [2];
  bit            lastDs [2];
  bit            gDs [2];
  bit            gWe [2];
  logic [AW-1:0] gAddr [2];
  logic [W-1:0]  gWdata [2];
  logic [W-1:0]  rvData [2];
  logic [AW-1:0] mAddr [2];
  logic [W-1:0]  mWdata [2];
  logic [W-1:0]  mRdata [2];
  logic [W-1:0]  memM [2][256];

  // RAM stub state.
  logic [W-1:0]  envMem [2][256];
  int            rdCyc [2];
  logic [AW-1:0] rdAddr [2];

  typedef struct {
    logic         rst;
    logic         rqIf;
    logic         weIf;
    logic [7:0]   adIf;
    logic [31:0]  wdIf;
    logic         rqDs;
    logic         weDs;
    logic [7:0]   adDs;
    logic [31:0]  wdDs;
    logic [6:0]   eBits;
    logic [7:0]   eAddr;
    logic [31:0]  eWdata;
    logic [31:0]  eRdata;
  } vec_t;

  vec_t tbl[$];

  function automatic int latOf(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic vec_t mk(logic rst, logic rqI, logic weI, logic [7:0] adI, logic [31:0] wdI,
                              logic rqD, logic weD, logic [7:0] adD, logic [31:0] wdD,
                              logic [6:0] eb, logic [7:0] ea, logic [31:0] ew, logic [31:0] er);
    vec_t v;
    v.rst = rst; v.rqIf = rqI; v.weIf = weI; v.adIf = adI; v.wdIf = wdI;
    v.rqDs = rqD; v.weDs = weD; v.adDs = adD; v.wdDs = wdD;
    v.eBits = eb; v.eAddr = ea; v.eWdata = ew; v.eRdata = er;
    return v;
  endfunction

  // {gnt_if, gnt_ds, ram_rd, ram_wr, rvalid_if, rvalid_ds, busy, ram_addr, ram_wdata, rdata}
  function automatic logic [127:0] actOf(int k);
    return 128'({gntIf[k], gntDs[k], ramRd[k], ramWr[k], rvIf[k], rvDs[k], busyO[k],
                 ramAddr[k], ramWdata[k], rdataO[k]});
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic modelInput(int k);
    int c = cyc;
    if (reset) begin
      freeAt[k] = c + 1;
      lastDs[k] = 1'b1;
      gntCyc[k] = -1;
      rvCyc[k]  = -1;
      mAddr[k]  = '0;
      mWdata[k] = '0;
      mRdata[k] = '0;
    end else if (c >= freeAt[k] && (reqIf || reqDs)) begin
      bit ds;
      ds        = (reqIf && reqDs) ? !lastDs[k] : reqDs;
      lastDs[k] = ds;
      gDs[k]    = ds;
      gWe[k]    = ds ? weDs : weIf;
      gAddr[k]  = ds ? addrDs : addrIf;
      gWdata[k] = ds ? wdataDs : wdataIf;
      gntCyc[k] = c + 1;
      if (gWe[k]) begin
        memM[k][gAddr[k]] = gWdata[k];
        freeAt[k] = c + 2;
      end else begin
        rvData[k] = memM[k][gAddr[k]];
        rvCyc[k]  = c + 2 + latOf(k);
        freeAt[k] = c + 3 + latOf(k);
      end
    end
  endtask

  task automatic modelCheck(int k);
    int c = cyc;
    bit g, r, bsy;
    if (c == gntCyc[k]) begin
      mAddr[k]  = gAddr[k];
      mWdata[k] = gWdata[k];
    end
    if (c == rvCyc[k]) mRdata[k] = rvData[k];
    g   = (c == gntCyc[k]);
    r   = (c == rvCyc[k]);
    bsy = (gntCyc[k] >= 0) && (c >= gntCyc[k]) && (c < freeAt[k]);
    check($sformatf("model_lat%0d", latOf(k)), actOf(k),
          128'({g && !gDs[k], g && gDs[k], g && !gWe[k], g && gWe[k],
                r && !gDs[k], r && gDs[k], bsy, mAddr[k], mWdata[k], mRdata[k]}));
  endtask

  task automatic envUpdate(int k);
    if (ramWr[k] === 1'b1) envMem[k][ramAddr[k]] = ramWdata[k];
    if (ramRd[k] === 1'b1) begin
      rdCyc[k]  = cyc;
      rdAddr[k] = ramAddr[k];
    end
    ramRdata[k] = (cyc == rdCyc[k] + latOf(k)) ? envMem[k][rdAddr[k]] : W'($urandom());
  endtask

  // Hands this cycle's inputs to the model, advances one clock, then checks.
  task automatic step();
    for (int k = 0; k < 2; k++) modelInput(k);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      envUpdate(k);
      modelCheck(k);
    end
  endtask

  task automatic idle(int n);
    reset = 1'b0; reqIf = 1'b0; reqDs = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic sawRv;
    int t0;
    for (int k = 0; k < 2; k++) begin
      freeAt[k] = 0; gntCyc[k] = -1; rvCyc[k] = -1; lastDs[k] = 1'b1;
      gDs[k] = 1'b0; gWe[k] = 1'b0; gAddr[k] = '0; gWdata[k] = '0; rvData[k] = '0;
      mAddr[k] = '0; mWdata[k] = '0; mRdata[k] = '0;
      rdCyc[k] = -100; rdAddr[k] = '0; ramRdata[k] = '0;
      for (int a = 0; a < 256; a++) begin
        logic [W-1:0] v;
        v = W'($urandom());
        envMem[k][a] = v;
        memM[k][a]   = v;
      end
      envMem[k][8'h10] = 32'hDEADBEEF; memM[k][8'h10] = 32'hDEADBEEF;
      envMem[k][8'h05] = 32'h0505A5A5; memM[k][8'h05] = 32'h0505A5A5;
    end

    // Directed table, expectations hand-derived for the RD_LAT=1 instance.
    tbl.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        7'b0000000, 8'h00, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        7'b1010001, 8'h10, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0,0,8'h10,32'h0,        0,0,8'h00,32'h0,        7'b0000001, 8'h10, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0,0,8'h10,32'h0,        0,0,8'h00,32'h0,        7'b0000101, 8'h10, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        1,1,8'h20,32'h12345678, 7'b0000000, 8'h10, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        0,1,8'h20,32'h12345678, 7'b0101001, 8'h20, 32'h12345678, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        7'b0000000, 8'h20, 32'h12345678, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b0000000, 8'h00, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b1001001, 8'h30, 32'hA1,       32'h0));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b0000000, 8'h30, 32'hA1,       32'h0));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b0101001, 8'h31, 32'hD1,       32'h0));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b0000000, 8'h31, 32'hD1,       32'h0));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b1001001, 8'h30, 32'hA1,       32'h0));
    tbl.push_back(mk(0, 1,1,8'h30,32'hA1,       1,1,8'h31,32'hD1,       7'b0000000, 8'h30, 32'hA1,       32'h0));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        7'b0101001, 8'h31, 32'hD1,       32'h0));
    tbl.push_back(mk(0, 1,1,8'h40,32'h44,       0,0,8'h00,32'h0,        7'b0000000, 8'h31, 32'hD1,       32'h0));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        1,0,8'h41,32'h0,        7'b1001001, 8'h40, 32'h44,       32'h0));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        7'b0000000, 8'h40, 32'h44,       32'h0));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        7'b0000000, 8'h40, 32'h44,       32'h0));
    tbl.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        7'b0000000, 8'h40, 32'h44,       32'h0));

    for (int i = 0; i < 3; i++) step();

    foreach (tbl[i]) begin
      check($sformatf("table_row%0d", i), actOf(0),
            128'({tbl[i].eBits, tbl[i].eAddr, tbl[i].eWdata, tbl[i].eRdata}));
      reset = tbl[i].rst;
      reqIf = tbl[i].rqIf; weIf = tbl[i].weIf; addrIf = tbl[i].adIf; wdataIf = tbl[i].wdIf;
      reqDs = tbl[i].rqDs; weDs = tbl[i].weDs; addrDs = tbl[i].adDs; wdataDs = tbl[i].wdDs;
      step();
    end
    idle(8);

    // RD_LAT=3: DS read at T returns at T+5; IF raised at T+2 is granted at T+7.
    t0 = cyc;
    for (int k = 0; k <= 8; k++) begin
      if (k == 4) check("lat3_no_early_rvalid", 128'(rvDs[1]), 128'(0));
      if (k == 5) check("lat3_rvalid_ds", 128'({rvDs[1], rvIf[1], rdataO[1]}), 128'({2'b10, 32'h0505A5A5}));
      if (k == 6) check("lat3_if_not_yet", 128'(gntIf[1]), 128'(0));
      if (k == 7) check("lat3_gnt_if", 128'({gntIf[1], gntDs[1]}), 128'(2'b10));
      reset = 1'b0;
      reqDs = (k <= 1); weDs = 1'b0; addrDs = 8'h05;
      reqIf = (k >= 2 && k <= 7); weIf = 1'b0; addrIf = 8'h11;
      step();
    end
    idle(10);

    // Reset during WAIT of an IF read on the RD_LAT=3 instance.
    sawRv = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k == 4) check("rst_wait_outputs_zero", actOf(1), 128'(0));
      if (k >= 4 && k <= 8) sawRv = sawRv | rvIf[1];
      if (k == 5) check("rst_wait_tie_to_if", 128'({gntIf[1], gntDs[1]}), 128'(2'b10));
      reset = (k == 3);
      reqIf = (k <= 1) || (k == 4) || (k == 5); weIf = 1'b0; addrIf = 8'h12;
      reqDs = (k == 4) || (k == 5); weDs = 1'b0; addrDs = 8'h13;
      step();
    end
    check("rst_wait_no_rvalid_if", 128'(sawRv), 128'(0));
    idle(10);

    // Randomized traffic, including occasional resets and withdrawn requests.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      reqIf = ($urandom_range(0, 2) != 0);
      reqDs = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        weIf = 1'($urandom()); addrIf = AW'($urandom_range(0, 15)); wdataIf = W'($urandom());
      end
      if ($urandom_range(0, 3) == 0) begin
        weDs = 1'($urandom()); addrDs = AW'($urandom_range(0, 15)); wdataDs = W'($urandom());
      end
      step();
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
